// File: rtl/nav_pkg.sv
// Shared navigation definitions: ultrasonic scheduler state encoding,
// sensor index map and default ping timing at 50 MHz.
package nav_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GAP
    } us_state_e;

    localparam int US_FRONT_IDX      = 0;
    localparam int US_BACK_IDX       = 1;
    localparam int US_SIDE_FRONT_IDX = 2;
    localparam int US_SIDE_BACK_IDX  = 3;

    localparam int US_NSENS_DEF        = 4;
    localparam int US_W_DEF            = 20;
    localparam int US_TRIG_CYC_DEF     = 250;
    localparam int US_RISE_TO_CYC_DEF  = 50000;
    localparam int US_ECHO_MAX_CYC_DEF = 925000;
    localparam int US_GAP_CYC_DEF      = 10000;

endpackage

// File: rtl/us_rr_select.sv
// Combinational round-robin picker: first enabled sensor after cur_i (or at
// cur_i itself when incl_i is set), wrapping at NSENS-1.
module us_rr_select
    import nav_pkg::*;
#(
    parameter int NSENS = US_NSENS_DEF,
    parameter int IW    = 2
) (
    input  logic [NSENS-1:0] mask_i,
    input  logic [IW-1:0]    cur_i,
    input  logic             incl_i,
    output logic [IW-1:0]    next_o,
    output logic             any_o
);

    assign any_o = |mask_i;

    always_comb begin
        logic found;
        found  = 1'b0;
        next_o = cur_i;
        for (int k = 0; k < NSENS; k++) begin
            int idx;
            idx = (int'(cur_i) + k + (incl_i ? 0 : 1)) % NSENS;
            if (!found && mask_i[IW'(idx)]) begin
                next_o = IW'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/us_ping_scheduler.sv
// Round-robin ultrasonic ping scheduler: fires one sensor at a time, times
// the echo width in clock cycles and publishes a per-sensor distance.
module us_ping_scheduler
    import nav_pkg::*;
#(
    parameter int  NSENS        = US_NSENS_DEF,
    parameter int  W            = US_W_DEF,
    parameter int  TRIG_CYC     = US_TRIG_CYC_DEF,
    parameter int  RISE_TO_CYC  = US_RISE_TO_CYC_DEF,
    parameter int  ECHO_MAX_CYC = US_ECHO_MAX_CYC_DEF,
    parameter int  GAP_CYC      = US_GAP_CYC_DEF,
    localparam int IW           = (NSENS > 1) ? $clog2(NSENS) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic [NSENS-1:0]   MASK,
    input  logic [NSENS-1:0]   US_I,
    output logic [NSENS-1:0]   US_O,
    output logic [NSENS-1:0]   US_OE,
    output logic [NSENS*W-1:0] DIST,
    output logic [NSENS-1:0]   VALID,
    output logic [NSENS-1:0]   ERR,
    output logic               BUSY,
    output logic [IW-1:0]      CUR
);

    if (longint'(ECHO_MAX_CYC) >= (longint'(1) << W)) begin : g_echo_max_too_wide
        $error("ECHO_MAX_CYC does not fit in the W-bit counter");
    end
    if (longint'(RISE_TO_CYC) >= (longint'(1) << W)) begin : g_rise_to_too_wide
        $error("RISE_TO_CYC does not fit in the W-bit counter");
    end

    localparam logic [W-1:0] TRIG_LAST = W'(TRIG_CYC - 1);
    localparam logic [W-1:0] RISE_LAST = W'(RISE_TO_CYC - 1);
    localparam logic [W-1:0] ECHO_LAST = W'(ECHO_MAX_CYC - 1);
    localparam logic [W-1:0] ECHO_SAT  = W'(ECHO_MAX_CYC);
    localparam logic [W-1:0] GAP_LAST  = W'(GAP_CYC - 1);

    us_state_e        state_q, state_d;
    logic [W-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]    cur_q, cur_d;
    logic             first_q, first_d;
    logic [NSENS-1:0] sync1_q, sync2_q;
    logic [W-1:0]     dist_q [NSENS];
    logic [W-1:0]     dist_d [NSENS];
    logic [NSENS-1:0] err_q, err_d;
    logic [NSENS-1:0] valid_q, valid_d;
    logic [IW-1:0]    next_idx;
    logic             any_en;
    logic             echo_cur;

    // first_q makes the very first search after reset include index 0 itself
    us_rr_select #(.NSENS(NSENS), .IW(IW)) u_rr_select (
        .mask_i (MASK),
        .cur_i  (cur_q),
        .incl_i (first_q),
        .next_o (next_idx),
        .any_o  (any_en)
    );

    assign echo_cur = sync2_q[cur_q];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cur_q   <= '0;
            first_q <= 1'b1;
            sync1_q <= '0;
            sync2_q <= '0;
            err_q   <= '0;
            valid_q <= '0;
            for (int n = 0; n < NSENS; n++) dist_q[n] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            first_q <= first_d;
            sync1_q <= US_I;
            sync2_q <= sync1_q;
            err_q   <= err_d;
            valid_q <= valid_d;
            for (int n = 0; n < NSENS; n++) dist_q[n] <= dist_d[n];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        first_d = first_q;
        err_d   = err_q;
        valid_d = '0;
        for (int n = 0; n < NSENS; n++) dist_d[n] = dist_q[n];

        unique case (state_q)
            IDLE: begin
                if (EN && any_en) begin
                    cur_d   = next_idx;
                    first_d = 1'b0;
                    cnt_d   = '0;
                    state_d = TRIG;
                end
            end
            TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_RISE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_RISE: begin
                if (echo_cur) begin
                    cnt_d   = W'(1);
                    state_d = MEASURE;
                end else if (cnt_q == RISE_LAST) begin
                    dist_d[cur_q] = '1;
                    err_d[cur_q]  = 1'b1;
                    valid_d[cur_q] = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MEASURE: begin
                if (!echo_cur) begin
                    dist_d[cur_q] = cnt_q;
                    err_d[cur_q]  = 1'b0;
                    valid_d[cur_q] = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (cnt_q == ECHO_LAST) begin
                    dist_d[cur_q] = ECHO_SAT;
                    err_d[cur_q]  = 1'b1;
                    valid_d[cur_q] = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                // a stuck-high echo keeps us here so the next ping never hears it
                if (cnt_q != GAP_LAST) cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST && !echo_cur) begin
                    cnt_d = '0;
                    if (EN && any_en) begin
                        cur_d   = next_idx;
                        state_d = TRIG;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        US_OE = '0;
        if (state_q == TRIG) US_OE[cur_q] = 1'b1;
    end

    assign US_O  = US_OE;
    assign VALID = valid_q;
    assign ERR   = err_q;
    assign BUSY  = (state_q != IDLE);
    assign CUR   = cur_q;

    for (genvar n = 0; n < NSENS; n++) begin : g_dist
        assign DIST[n*W +: W] = dist_q[n];
    end

endmodule

// File: tb/tb_us_ping_scheduler.sv
// Self-checking bench for us_ping_scheduler: a sensor echo responder plus a
// transaction-level model of ping order and results under reduced timing.
module tb_us_ping_scheduler;

    localparam int NS   = 4;
    localparam int W    = 20;
    localparam int TRIG = 4;
    localparam int RISE = 50;
    localparam int EMAX = 1000;
    localparam int GAPC = 8;
    localparam int NEVER = 1 << 28;

    logic          CLK;
    logic          RST;
    logic          EN;
    logic [NS-1:0] MASK;
    logic [NS-1:0] US_I;
    logic [NS-1:0] US_O;
    logic [NS-1:0] US_OE;
    logic [NS*W-1:0] DIST;
    logic [NS-1:0] VALID;
    logic [NS-1:0] ERR;
    logic          BUSY;
    logic [1:0]    CUR;

    int checks   = 0;
    int failures = 0;

    int dly [NS];
    int len [NS];
    int fallCyc [NS];

    int cyc = 0;
    int trigQ[$];
    int trigCyc[$];
    int vSens[$];
    int vDist[$];
    int vErr[$];
    int vCyc[$];
    int relCyc [NS];
    int oeLen [NS];
    int oeRun [NS];
    int exclViol = 0;
    int busySeen = 0;
    int oeSeen   = 0;

    us_ping_scheduler #(
        .NSENS(NS), .W(W), .TRIG_CYC(TRIG), .RISE_TO_CYC(RISE),
        .ECHO_MAX_CYC(EMAX), .GAP_CYC(GAPC)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .MASK(MASK), .US_I(US_I),
        .US_O(US_O), .US_OE(US_OE), .DIST(DIST), .VALID(VALID),
        .ERR(ERR), .BUSY(BUSY), .CUR(CUR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Sensor model: after a trigger is released the line goes high after
    // dly[n] cycles and stays high for len[n] cycles.
    initial begin
        int t [NS];
        logic [NS-1:0] prevOe;
        prevOe = '0;
        US_I = '0;
        for (int n = 0; n < NS; n++) t[n] = -1;
        forever begin
            @(posedge CLK);
            #1;
            for (int n = 0; n < NS; n++) begin
                logic was;
                was = US_I[n];
                if (RST) begin
                    t[n] = -1;
                    US_I[n] = 1'b0;
                end else begin
                    if (prevOe[n] && !US_OE[n]) t[n] = 0;
                    else if (t[n] >= 0) t[n]++;
                    US_I[n] = (t[n] >= dly[n]) && (t[n] < dly[n] + len[n]);
                    if (was && !US_I[n]) fallCyc[n] = cyc;
                end
            end
            prevOe = US_OE;
        end
    end

    // Transaction monitor: records triggers, releases and published results.
    initial begin
        logic [NS-1:0] prevOe;
        prevOe = '0;
        forever begin
            @(posedge CLK);
            #3;
            cyc++;
            if (!RST) begin
                if ($countones(US_OE) > 1) exclViol++;
                if (BUSY) busySeen++;
                if (US_OE != '0) oeSeen++;
                for (int n = 0; n < NS; n++) begin
                    if (US_OE[n] && !prevOe[n]) begin
                        trigQ.push_back(n);
                        trigCyc.push_back(cyc);
                        oeRun[n] = 0;
                    end
                    if (US_OE[n]) oeRun[n]++;
                    if (!US_OE[n] && prevOe[n]) begin
                        oeLen[n]  = oeRun[n];
                        relCyc[n] = cyc;
                    end
                    if (VALID[n]) begin
                        vSens.push_back(n);
                        vDist.push_back(int'(DIST[n*W +: W]));
                        vErr.push_back(int'(ERR[n]));
                        vCyc.push_back(cyc);
                    end
                end
            end
            prevOe = US_OE;
        end
    end

    function automatic int qAt(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NS-1:0] m, input logic e);
        @(negedge CLK);
        MASK = m;
        EN   = e;
    endtask

    task automatic clearLogs();
        trigQ.delete(); trigCyc.delete();
        vSens.delete(); vDist.delete(); vErr.delete(); vCyc.delete();
        exclViol = 0; busySeen = 0; oeSeen = 0;
    endtask

    task automatic resetDut();
        @(negedge CLK);
        RST = 1'b1;
        EN  = 1'b0;
        repeat (3) @(negedge CLK);
        clearLogs();
        RST = 1'b0;
    endtask

    task automatic waitValid(input int n, input int budget, input string tag);
        int k = 0;
        while (vSens.size() < n && k < budget) begin
            @(negedge CLK);
            k++;
        end
        checkOutput(tag, 32'(vSens.size()), 32'(n));
    endtask

    task automatic waitTrig(input int n, input int budget, input string tag);
        int k = 0;
        while (trigQ.size() < n && k < budget) begin
            @(negedge CLK);
            k++;
        end
        checkOutput(tag, 32'(trigQ.size()), 32'(n));
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int k = 0;
        while (BUSY !== 1'b0 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        checkOutput(tag, 32'(BUSY), 32'd0);
    endtask

    initial begin
        int order [5];
        int m;
        int s;
        int cnt2;

        RST = 1'b1; EN = 1'b0; MASK = '0;
        for (int n = 0; n < NS; n++) begin
            dly[n] = 10; len[n] = 100; fallCyc[n] = 0;
            relCyc[n] = 0; oeLen[n] = 0; oeRun[n] = 0;
        end

        // reset state
        repeat (3) @(negedge CLK);
        checkOutput("rst_oe",    32'(US_OE), 32'd0);
        checkOutput("rst_busy",  32'(BUSY),  32'd0);
        checkOutput("rst_valid", 32'(VALID), 32'd0);
        checkOutput("rst_dist",  32'(|DIST), 32'd0);
        checkOutput("rst_err",   32'(ERR),   32'd0);
        checkOutput("rst_cur",   32'(CUR),   32'd0);
        clearLogs();
        RST = 1'b0;

        // basic single ping on sensor 0
        dly[0] = 10; len[0] = 300;
        applyStimulus(4'b0001, 1'b1);
        waitValid(1, 1000, "basic_wait_valid");
        EN = 1'b0;
        waitIdle(200, "basic_idle");
        checkOutput("basic_sens",   32'(qAt(vSens, 0)), 32'd0);
        checkOutput("basic_dist",   32'(qAt(vDist, 0)), 32'd300);
        checkOutput("basic_err",    32'(qAt(vErr, 0)),  32'd0);
        checkOutput("basic_oe_len", 32'(oeLen[0]),      32'(TRIG));
        checkOutput("basic_npulse", 32'(vSens.size()),  32'd1);

        // round robin with mask 1011 and random echo widths
        resetDut();
        for (int n = 0; n < NS; n++) begin
            dly[n] = int'($urandom_range(3, 30));
            len[n] = int'($urandom_range(20, 900));
        end
        order[0] = 0; order[1] = 1; order[2] = 3; order[3] = 0;
        applyStimulus(4'b1011, 1'b1);
        waitValid(4, 6000, "rr_wait_valid");
        EN = 1'b0;
        waitIdle(2000, "rr_idle");
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rr_trig%0d", i), 32'(qAt(trigQ, i)), 32'(order[i]));
            checkOutput($sformatf("rr_sens%0d", i), 32'(qAt(vSens, i)), 32'(order[i]));
            checkOutput($sformatf("rr_dist%0d", i), 32'(qAt(vDist, i)), 32'(len[order[i]]));
            checkOutput($sformatf("rr_err%0d", i),  32'(qAt(vErr, i)),  32'd0);
        end
        cnt2 = 0;
        foreach (trigQ[i]) if (trigQ[i] == 2) cnt2++;
        checkOutput("rr_skip2",   32'(cnt2),         32'd0);
        checkOutput("rr_ntrig",   32'(trigQ.size()), 32'd4);
        checkOutput("rr_excl",    32'(exclViol),     32'd0);
        checkOutput("rr_persist", 32'(DIST[2*W +: W]), 32'd0);

        // random nonzero mask, five pings, order from cyclic next-set-bit search
        resetDut();
        m = int'($urandom_range(1, 15));
        for (int n = 0; n < NS; n++) begin
            dly[n] = int'($urandom_range(3, 30));
            len[n] = int'($urandom_range(20, 500));
        end
        s = 0;
        while (((m >> s) & 1) == 0) s++;
        order[0] = s;
        for (int i = 1; i < 5; i++) begin
            s = (s + 1) % NS;
            while (((m >> s) & 1) == 0) s = (s + 1) % NS;
            order[i] = s;
        end
        applyStimulus(4'(m), 1'b1);
        waitValid(5, 6000, "rand_wait_valid");
        EN = 1'b0;
        waitIdle(2000, "rand_idle");
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("rand_m%0h_trig%0d", m, i), 32'(qAt(trigQ, i)), 32'(order[i]));
            checkOutput($sformatf("rand_m%0h_dist%0d", m, i), 32'(qAt(vDist, i)), 32'(len[order[i]]));
        end
        checkOutput("rand_excl", 32'(exclViol), 32'd0);

        // rise timeout on sensor 1, saturation and stuck echo on sensor 2
        resetDut();
        dly[1] = NEVER; len[1] = 10;
        dly[2] = 10;    len[2] = 2000;
        applyStimulus(4'b0110, 1'b1);
        waitValid(1, 500, "to_wait_valid1");
        checkOutput("to_sens1",  32'(qAt(vSens, 0)), 32'd1);
        checkOutput("to_dist1",  32'(qAt(vDist, 0)), 32'hFFFFF);
        checkOutput("to_err1",   32'(qAt(vErr, 0)),  32'd1);
        checkOutput("to_delay1", 32'(qAt(vCyc, 0) - relCyc[1]), 32'(RISE));
        waitValid(2, 3000, "to_wait_valid2");
        checkOutput("sat_sens2", 32'(qAt(vSens, 1)), 32'd2);
        checkOutput("sat_dist2", 32'(qAt(vDist, 1)), 32'(EMAX));
        checkOutput("sat_err2",  32'(qAt(vErr, 1)),  32'd1);
        checkOutput("sat_busy",  32'(BUSY), 32'd1);
        checkOutput("sat_cur",   32'(CUR),  32'd2);
        waitTrig(3, 3000, "stuck_wait_trig");
        checkOutput("stuck_next", 32'(qAt(trigQ, 2)), 32'd1);
        checkOutput("stuck_hold", 32'(qAt(trigCyc, 2) > fallCyc[2]), 32'd1);
        EN = 1'b0;
        waitIdle(500, "to_idle");

        // EN dropped while sensor 0 echo is being measured
        resetDut();
        dly[0] = 5; len[0] = 200;
        applyStimulus(4'b0001, 1'b1);
        waitTrig(1, 100, "endrop_wait_trig");
        repeat (40) @(negedge CLK);
        EN = 1'b0;
        waitIdle(1000, "endrop_idle");
        checkOutput("endrop_nvalid", 32'(vSens.size()), 32'd1);
        checkOutput("endrop_dist",   32'(qAt(vDist, 0)), 32'd200);
        checkOutput("endrop_err",    32'(qAt(vErr, 0)),  32'd0);
        repeat (100) @(negedge CLK);
        checkOutput("endrop_ntrig", 32'(trigQ.size()), 32'd1);
        checkOutput("endrop_busy",  32'(BUSY), 32'd0);

        // reset on the second cycle of sensor 1's trigger
        resetDut();
        dly[0] = 5; len[0] = 30;
        dly[1] = 5; len[1] = 30;
        applyStimulus(4'b0011, 1'b1);
        waitTrig(2, 500, "rsttrig_wait_trig");
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("rsttrig_oe",    32'(US_OE), 32'd0);
        checkOutput("rsttrig_busy",  32'(BUSY),  32'd0);
        checkOutput("rsttrig_dist",  32'(|DIST), 32'd0);
        checkOutput("rsttrig_valid", 32'(VALID), 32'd0);
        clearLogs();
        RST = 1'b0;
        waitTrig(1, 100, "rsttrig_wait_restart");
        checkOutput("rsttrig_first", 32'(qAt(trigQ, 0)), 32'd0);
        EN = 1'b0;
        waitIdle(500, "rsttrig_idle");

        // empty mask never leaves IDLE
        resetDut();
        applyStimulus(4'b0000, 1'b1);
        repeat (1000) @(negedge CLK);
        checkOutput("mask0_busyseen", 32'(busySeen), 32'd0);
        checkOutput("mask0_oeseen",   32'(oeSeen),   32'd0);
        checkOutput("mask0_busy",     32'(BUSY),     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/us_ping_scheduler.md
Name: us_ping_scheduler

Overview:
- Time-multiplexes the four single-wire ultrasonic ping sensors (front, back, side-front, side-back) so that only one sensor fires at a time, which prevents acoustic crosstalk.
- For each sensor it drives the trigger pulse, measures the echo width in clock cycles, handles timeouts and publishes the result.
- Navigation consumes the published distances. The top level owns the tristate pads and connects them through per-sensor O/OE/I lines.

Parameters:
- NSENS, 4, number of sensors sequenced (sensor index 0..NSENS-1).
- W, 20, distance counter/result width in bits.
- TRIG_CYC, 250, trigger high time in cycles (5 us at 50 MHz).
- RISE_TO_CYC, 50000, maximum cycles from trigger release to echo rise (1 ms).
- ECHO_MAX_CYC, 925000, echo width saturation limit (18.5 ms).
- GAP_CYC, 10000, minimum quiet cycles between pings (200 us).

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  1 = run the round-robin scan.
- MASK  in  NSENS  per-sensor enable; a 0 bit skips that sensor.
- US_I  in  NSENS  pad input from the sensor lines; asynchronous.
- US_O  out  NSENS  pad drive value.
- US_OE  out  NSENS  pad output enable; 1 = drive.
- DIST  out  NSENS*W  last result per sensor, sensor n in bits [n*W +: W].
- VALID  out  NSENS  one-cycle pulse when DIST[n] updates.
- ERR  out  NSENS  per-sensor flag, updated with each result; 1 = that result timed out.
- BUSY  out  1  1 whenever the FSM is not in IDLE.
- CUR  out  2  index of the sensor currently being serviced.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, CUR=0, all counters 0. US_OE=0 on the first edge with RST high, including when reset arrives mid-ping.
- Synchroniser: each US_I bit passes through a 2-flop synchroniser. All echo logic uses only the synchronised value (echo_s).
- Sensor selection: next = first index with MASK=1, searching from CUR+1 upward with wrap at NSENS-1 -> 0. If only CUR is enabled, it is reselected. MASK is sampled only in IDLE and GAP.
- IDLE:
  - If EN=1 and MASK!=0, select the next sensor and go to TRIG.
  - After reset the search starts at index 0 itself, so sensor 0 is serviced first if enabled.
  - Otherwise stay in IDLE.
- TRIG: US_OE[CUR]=1 and US_O[CUR]=1 for exactly TRIG_CYC cycles. Then release (OE=0, O=0) and go to WAIT_RISE with the counter cleared.
- WAIT_RISE:
  - On echo_s[CUR]=1, go to MEASURE with the counter at 1.
  - If the counter reaches RISE_TO_CYC first: DIST[CUR] = all ones, ERR[CUR]=1, pulse VALID[CUR], go to GAP.
- MEASURE: increment the counter each cycle while echo_s[CUR]=1.
  - On echo_s fall: DIST[CUR] = count, ERR[CUR]=0, pulse VALID[CUR] on the cycle after the fall is seen, go to GAP.
  - If the count reaches ECHO_MAX_CYC while echo_s is still high: DIST[CUR]=ECHO_MAX_CYC, ERR[CUR]=1, pulse VALID[CUR], go to GAP.
- GAP:
  - Wait until GAP_CYC cycles have elapsed and echo_s[CUR]=0. A stuck-high echo holds the FSM in GAP.
  - Then, if EN=1 and MASK!=0, select the next sensor and go to TRIG; else go to IDLE.
- EN deassert mid-ping: the current ping completes through GAP, then the FSM goes to IDLE. A ping is never truncated except by RST.
- Exclusivity: at most one US_OE bit is high at any time. Non-selected O/OE bits are always 0.
- Result persistence: DIST and ERR for sensors not being serviced hold their values. A new result overwrites the old one.
- Widths:
  - The counter is W bits and saturates; it never wraps.
  - The elaborator errors if ECHO_MAX_CYC or RISE_TO_CYC is at least 2^W.

Decomposition:
- Shared package nav_pkg holds:
  - the state encoding (IDLE, TRIG, WAIT_RISE, MEASURE, GAP);
  - sensor index constants US_FRONT_IDX=0, US_BACK_IDX=1, US_SIDE_FRONT_IDX=2, US_SIDE_BACK_IDX=3;
  - the default timing constants.
- One sub-module, us_rr_select: combinational round-robin next-index picker, inputs MASK and CUR, outputs next index and an any-enabled flag.
- The synchroniser is inline.

Test Plan:
All scenarios use overrides TRIG_CYC=4, RISE_TO_CYC=50, ECHO_MAX_CYC=1000, GAP_CYC=8, W=20.
- Basic ping: MASK=4'b0001, EN=1, echo model raises US_I[0] 10 cycles after release and holds it 300 cycles -> OE[0] high exactly 4 cycles; DIST[0]=300; ERR[0]=0; one VALID[0] pulse.
- Round robin: MASK=4'b1011, all echoes 100 cycles -> service order 0,1,3,0; sensor 2 never triggered; each VALID pulse with DIST=100; no two OE bits high at once.
- Timeouts: sensor 1 never echoes -> DIST[1]=20'hFFFFF, ERR[1]=1 at 50 cycles after release. Sensor 2 echo held 2000 cycles -> DIST[2]=1000, ERR[2]=1; FSM stays in GAP until the echo falls.
- EN drop mid-MEASURE: deassert EN during sensor 0's echo -> sensor 0 result still delivered, FSM reaches IDLE after GAP, no further TRIG.
- Reset mid-TRIG: assert RST on cycle 2 of TRIG -> next edge US_OE=0, BUSY=0, DIST=0, VALID=0; after release the scan restarts at sensor 0.
- MASK=0 with EN=1 -> FSM stays IDLE, BUSY=0, no OE activity for 1000 cycles.
